// File: rtl/tta_ifetch_pkg.sv
// rtl/tta_ifetch_pkg.sv - shared types and constants for the instruction fetch buffer
package tta_ifetch_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_ADDRESS  = 28;
   localparam int DEF_LINEBITS = 4;
   localparam int LINE_WORDS   = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HIT    = 3'd1,
      S_MREQ   = 3'd2,
      S_FILL   = 3'd3,
      S_STREAM = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

endpackage

// File: rtl/tta_ifetch_buf_line_ram.sv
// rtl/tta_ifetch_buf_line_ram.sv - one-line word store with a synchronous write port and a registered read port
module tta_line_ram
   import tta_ifetch_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int LINEBITS = DEF_LINEBITS
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                we_i,
   input  logic [LINEBITS-1:0] waddr_i,
   input  logic [WIDTH-1:0]    wdata_i,
   input  logic [LINEBITS-1:0] raddr_i,
   output logic [WIDTH-1:0]    rdata_o
);

   logic [WIDTH-1:0] mem [2**LINEBITS];

   // Fill beats land in the array; the array itself needs no reset
   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Registered read so the core-facing data comes straight from a flop
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rdata_o <= '0;
      end else begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/tta_ifetch_buf.sv
// rtl/tta_ifetch_buf.sv - tagged one-line fetch buffer; TTA_IFETCH_BYPASS_EN forwards fill beats to the core
module tta_ifetch_buf
   import tta_ifetch_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ADDRESS  = DEF_ADDRESS,
   parameter int LINEBITS = DEF_LINEBITS
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               i_read_i,
   input  logic               i_abort_i,
   input  logic               i_flush_i,
   input  logic [ADDRESS-1:0] i_addr_i,
   output logic               i_rack_o,
   output logic               i_ready_o,
   output logic [WIDTH-1:0]   i_data_o,
   output logic               m_read_o,
   input  logic               m_rack_i,
   input  logic               m_ready_i,
   output logic [ADDRESS-1:0] m_addr_o,
   input  logic [WIDTH-1:0]   m_data_i
);

   localparam int TAGBITS = ADDRESS - LINEBITS;
   localparam logic [LINEBITS-1:0] CNT_ONE  = LINEBITS'(1);
   localparam logic [LINEBITS-1:0] CNT_LAST = {LINEBITS{1'b1}};
`ifdef TTA_IFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   state_t              state_q, state_d;
   logic [TAGBITS-1:0]  tag_q;
   logic                valid_q;
   logic                flushed_q;
   logic                acked_q;
   logic [LINEBITS-1:0] fcnt_q;
   logic [LINEBITS-1:0] scnt_q;
   logic                tag_hit;
   logic                miss_start;
   logic                beat;
   logic                last_beat;
   logic [LINEBITS-1:0] ram_raddr;
   logic [WIDTH-1:0]    ram_rdata;
   logic                unused_addr_bits;

   // Word-within-line bits never select anything: every request starts at word 0
   assign unused_addr_bits = ^i_addr_i[LINEBITS-1:0];

   // A flush on the request cycle already defeats the hit
   assign tag_hit    = valid_q && !i_flush_i && (i_addr_i[ADDRESS-1:LINEBITS] == tag_q);
   assign miss_start = (state_q == S_IDLE) && i_read_i && !tag_hit;
   assign beat       = m_ready_i && ((state_q == S_FILL) || (state_q == S_DRAIN));
   assign last_beat  = beat && (fcnt_q == CNT_LAST);

   // Read one word ahead of the stream counter to hide the registered RAM read
   assign ram_raddr = (state_q == S_STREAM) ? scnt_q + CNT_ONE : '0;

   // An abort before memory took the burst still has to issue it from DRAIN
   assign m_read_o = (state_q == S_MREQ) || ((state_q == S_DRAIN) && !acked_q);
   assign m_addr_o = {tag_q, {LINEBITS{1'b0}}};

   tta_line_ram #(
      .WIDTH    (WIDTH),
      .LINEBITS (LINEBITS)
   ) u_line_ram (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .we_i     (beat),
      .waddr_i  (fcnt_q),
      .wdata_i  (m_data_i),
      .raddr_i  (ram_raddr),
      .rdata_o  (ram_rdata)
   );

   // FSM state register
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a final beat beats a simultaneous abort since the burst is already over
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_read_i) begin
               state_d = tag_hit ? S_HIT : S_MREQ;
            end
         end
         S_HIT: begin
            state_d = i_abort_i ? S_IDLE : S_STREAM;
         end
         S_MREQ: begin
            if (i_abort_i) begin
               state_d = S_DRAIN;
            end else if (m_rack_i) begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (last_beat) begin
               state_d = (BYPASS || i_abort_i) ? S_IDLE : S_HIT;
            end else if (i_abort_i) begin
               state_d = S_DRAIN;
            end
         end
         S_STREAM: begin
            if (i_abort_i || (scnt_q == CNT_LAST)) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (last_beat) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Tag, valid and counters; a flush anywhere in a fill keeps that line invalid
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tag_q     <= '0;
         valid_q   <= 1'b0;
         flushed_q <= 1'b0;
         acked_q   <= 1'b0;
         fcnt_q    <= '0;
         scnt_q    <= '0;
      end else begin
         if (miss_start) begin
            tag_q     <= i_addr_i[ADDRESS-1:LINEBITS];
            valid_q   <= 1'b0;
            flushed_q <= 1'b0;
            acked_q   <= 1'b0;
            fcnt_q    <= '0;
         end
         if (m_read_o && m_rack_i) begin
            acked_q <= 1'b1;
         end
         if (beat) begin
            fcnt_q <= fcnt_q + CNT_ONE;
         end
         if (i_flush_i) begin
            valid_q   <= 1'b0;
            flushed_q <= 1'b1;
         end else if (last_beat && !flushed_q) begin
            valid_q <= 1'b1;
         end
         if (state_q == S_HIT) begin
            scnt_q <= '0;
         end else if (state_q == S_STREAM) begin
            scnt_q <= scnt_q + CNT_ONE;
         end
      end
   end

`ifdef TTA_IFETCH_BYPASS_EN
   logic             fwd_valid_q;
   logic             rack_q;
   logic [WIDTH-1:0] fwd_data_q;

   // Forward fill beats one cycle late, gaps included, and acknowledge once memory takes the burst
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= '0;
         rack_q      <= 1'b0;
      end else begin
         fwd_valid_q <= (state_q == S_FILL) && m_ready_i && !i_abort_i;
         if (beat) begin
            fwd_data_q <= m_data_i;
         end
         rack_q <= (state_q == S_MREQ) && m_rack_i && !i_abort_i;
      end
   end

   assign i_rack_o  = (state_q == S_HIT) || rack_q;
   assign i_ready_o = (state_q == S_STREAM) || fwd_valid_q;
   assign i_data_o  = (state_q == S_STREAM) ? ram_rdata : fwd_data_q;
`else
   assign i_rack_o  = (state_q == S_HIT);
   assign i_ready_o = (state_q == S_STREAM);
   assign i_data_o  = ram_rdata;
`endif

endmodule

// File: tb/tb_tta_ifetch_buf.sv
// tb/tb_tta_ifetch_buf.sv - directed scoreboard bench for tta_ifetch_buf
module tb_tta_ifetch_buf;

`ifdef TTA_IFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock_i;
   logic        reset_i;
   logic        i_read_i;
   logic        i_abort_i;
   logic        i_flush_i;
   logic [27:0] i_addr_i;
   logic        i_rack_o;
   logic        i_ready_o;
   logic [31:0] i_data_o;
   logic        m_read_o;
   logic        m_rack_i;
   logic        m_ready_i;
   logic [27:0] m_addr_o;
   logic [31:0] m_data_i;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] line_m [16];

   tta_ifetch_buf dut (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .i_read_i  (i_read_i),
      .i_abort_i (i_abort_i),
      .i_flush_i (i_flush_i),
      .i_addr_i  (i_addr_i),
      .i_rack_o  (i_rack_o),
      .i_ready_o (i_ready_o),
      .i_data_o  (i_data_o),
      .m_read_o  (m_read_o),
      .m_rack_i  (m_rack_i),
      .m_ready_i (m_ready_i),
      .m_addr_o  (m_addr_o),
      .m_data_i  (m_data_i)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rack"},  64'(i_rack_o),  64'(0));
      chk({tag, "_ready"}, 64'(i_ready_o), 64'(0));
      chk({tag, "_data"},  64'(i_data_o),  64'(0));
      chk({tag, "_mread"}, 64'(m_read_o),  64'(0));
      chk({tag, "_maddr"}, 64'(m_addr_o),  64'(0));
   endtask

   // Every word the core sees is popped from the scoreboard
   always @(negedge clock_i) begin
      if (!reset_i && i_ready_o) begin
         chk("sb_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            chk("sb_data", 64'(i_data_o), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic beat_cycle(input logic rdy, input logic [31:0] data, input logic exp_rdy);
      m_ready_i = rdy;
      m_data_i  = data;
      step();
      m_ready_i = 1'b0;
      i_flush_i = 1'b0;
      chk("fill_ready", 64'(i_ready_o), 64'(exp_rdy));
   endtask

   task automatic do_miss(input logic [27:0] addr, input logic [31:0] base, input int rack_wait,
                          input int gap, input int abort_after, input int flush_at, input int stop_at);
      int cnt;
      bit aborted;
      aborted  = 1'b0;
      i_read_i = 1'b1;
      i_addr_i = addr;
      step();
      chk("miss_addr", 64'(m_addr_o), 64'({addr[27:4], 4'h0}));
      cnt = 0;
      for (int i = 0; i < rack_wait; i++) begin
         if (m_read_o) cnt++;
         m_rack_i = (i == rack_wait - 1);
         step();
      end
      m_rack_i = 1'b0;
      chk("mread_len",  64'(cnt), 64'(rack_wait));
      chk("mread_drop", 64'(m_read_o), 64'(0));
      chk("miss_rack",  64'(i_rack_o), 64'(BYP));
      i_read_i = !BYP;
      for (int k = 0; k < 16; k++) begin
         if (k == stop_at) begin
            beat_cycle(1'b0, 32'h0, 1'b0);
            reset_i = 1'b1;
            #1;
            chk_zero("midfill_rst");
            step();
            reset_i  = 1'b0;
            i_read_i = 1'b0;
            chk("midfill_sb_empty", 64'(exp_q.size()), 64'(0));
            return;
         end
         if (k == abort_after) begin
            i_abort_i = 1'b1;
            i_read_i  = 1'b0;
            beat_cycle(1'b0, 32'h0, 1'b0);
            i_abort_i = 1'b0;
            aborted   = 1'b1;
         end
         line_m[k] = base + 32'(k);
         if (BYP && !aborted) exp_q.push_back(line_m[k]);
         i_flush_i = (k == flush_at);
         beat_cycle(1'b1, line_m[k], BYP && !aborted);
         if (k < 15) begin
            for (int g = 0; g < gap; g++) beat_cycle(1'b0, 32'h0, 1'b0);
         end
      end
`ifndef TTA_IFETCH_BYPASS_EN
      if (!aborted) begin
         chk("fill_rack", 64'(i_rack_o), 64'(1));
         i_read_i = 1'b0;
         for (int k = 0; k < 16; k++) exp_q.push_back(line_m[k]);
         step();
         chk("fill_rack_pulse", 64'(i_rack_o), 64'(0));
         cnt = 0;
         for (int i = 0; i < 16; i++) begin
            if (i_ready_o) cnt++;
            step();
         end
         chk("fill_words", 64'(cnt), 64'(16));
         chk("fill_end",   64'(i_ready_o), 64'(0));
      end else begin
         chk("drain_rack", 64'(i_rack_o), 64'(0));
      end
`endif
      step();
      chk("miss_sb_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_hit(input logic [27:0] addr, input int abort_at, input bit abort_with_req);
      int cnt;
      i_read_i  = 1'b1;
      i_addr_i  = addr;
      i_abort_i = abort_with_req;
      for (int k = 0; k < 16 && k <= abort_at; k++) exp_q.push_back(line_m[k]);
      step();
      i_abort_i = 1'b0;
      chk("hit_rack",  64'(i_rack_o), 64'(1));
      chk("hit_nomem", 64'(m_read_o), 64'(0));
      i_read_i = 1'b0;
      step();
      chk("hit_rack_pulse", 64'(i_rack_o), 64'(0));
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i_ready_o) cnt++;
         i_abort_i = (i == abort_at);
         step();
         if (i == abort_at) chk("abort_drop", 64'(i_ready_o), 64'(0));
      end
      i_abort_i = 1'b0;
      chk("hit_words", 64'(cnt), 64'((abort_at < 16) ? abort_at + 1 : 16));
      chk("hit_end", 64'(i_ready_o), 64'(0));
      chk("hit_sb_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      reset_i   = 1'b1;
      i_read_i  = 1'b0;
      i_abort_i = 1'b0;
      i_flush_i = 1'b0;
      i_addr_i  = '0;
      m_rack_i  = 1'b0;
      m_ready_i = 1'b0;
      m_data_i  = '0;
      repeat (2) @(posedge clock_i);
      #1;
      chk_zero("rst");
      reset_i = 1'b0;
      step();
      chk_zero("post_rst");

      // Cold miss, rack after 3 cycles of m_read_o
      do_miss(28'h0000120, 32'hA0, 3, 0, 99, -1, 99);
      // Hit on the same line, then a back-to-back hit with abort ignored in IDLE
      do_hit(28'h000012C, 99, 1'b0);
      do_hit(28'h000012C, 99, 1'b1);
      // Abort at stream word 5, then the line restarts at word 0
      do_hit(28'h0000120, 5, 1'b0);
      do_hit(28'h0000125, 99, 1'b0);
      // Miss aborted after 4 beats drains the rest and leaves the line valid
      do_miss(28'h0000200, 32'hB0, 1, 0, 4, -1, 99);
      do_hit(28'h0000200, 99, 1'b0);
      // Flush during beat 10 with gapped beats, then flush on the 16th beat
      do_miss(28'h0000300, 32'hC0, 2, 2, 99, 10, 99);
      do_miss(28'h0000300, 32'hD0, 1, 0, 99, 15, 99);
      do_miss(28'h0000300, 32'hE0, 1, 1, 99, -1, 99);
      do_hit(28'h000030F, 99, 1'b0);
      // Reset mid-fill drops the burst and invalidates the line
      do_miss(28'h0000400, 32'hF0, 2, 0, 99, -1, 5);
      do_miss(28'h0000300, 32'h60, 1, 0, 99, -1, 99);
      do_hit(28'h0000300, 99, 1'b0);

      chk("final_sb_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
